// File: rtl/ram_loader.sv
// ram_loader: byte-stream programmer for a 256x12 RAM.
// A session is: start, then address byte, count byte (0 means 256), then
// HI/LO byte pairs per 12-bit word. Each word is written in its own WRITE cycle.
// Ports:
//   clk, clr        clock and synchronous active-high reset
//   start           begin a session (sampled only while idle)
//   in_data/valid   byte stream in; in_ready says a byte is taken this cycle
//   a, d, we        RAM address, write data, write enable
//   prog            RAM programming mode (tristates RAM output)
//   busy, done      session in progress / one-cycle end-of-session pulse
//   err             sticky flag: a HI byte had non-zero upper nibble
module ram_loader (
   input  logic        clk,
   input  logic        clr,
   input  logic        start,
   input  logic [7:0]  in_data,
   input  logic        in_valid,
   output logic        in_ready,
   output logic [7:0]  a,
   output logic [11:0] d,
   output logic        we,
   output logic        prog,
   output logic        busy,
   output logic        done,
   output logic        err
);

   localparam int unsigned AW = 8;
   localparam int unsigned DW = 12;
   localparam int unsigned CW = 9;

   typedef enum logic [2:0] {
      S_IDLE,
      S_ADDR,
      S_CNT,
      S_HI,
      S_LO,
      S_WRITE,
      S_DONE
   } state_e;

   state_e        state_q, state_d;
   logic [AW-1:0] addr_q, addr_d;
   logic [DW-1:0] data_q, data_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          err_q, err_d;
   logic          in_ready_q, in_ready_d;
   logic          prog_q, prog_d;
   logic          busy_q, busy_d;
   logic          we_q, we_d;
   logic          done_q, done_d;

   // Next-state, datapath updates, and next values of the registered outputs.
   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      data_d  = data_q;
      cnt_d   = cnt_q;
      err_d   = err_q;

      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d = S_ADDR;
               err_d   = 1'b0;
            end
         end
         S_ADDR: begin
            if (in_valid) begin
               addr_d  = in_data;
               state_d = S_CNT;
            end
         end
         S_CNT: begin
            if (in_valid) begin
               // A count byte of zero stands for a full 256-word load.
               cnt_d   = (in_data == 8'd0) ? CW'(256) : CW'(in_data);
               state_d = S_HI;
            end
         end
         S_HI: begin
            if (in_valid) begin
               data_d = {in_data[3:0], data_q[7:0]};
               if (in_data[7:4] != 4'd0) begin
                  err_d = 1'b1;
               end
               state_d = S_LO;
            end
         end
         S_LO: begin
            if (in_valid) begin
               data_d  = {data_q[11:8], in_data};
               state_d = S_WRITE;
            end
         end
         S_WRITE: begin
            addr_d  = addr_q + AW'(1);
            cnt_d   = cnt_q - CW'(1);
            state_d = (cnt_q == CW'(1)) ? S_DONE : S_HI;
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      // Outputs are decoded from the next state so they are flops aligned to state_q.
      in_ready_d = (state_d == S_ADDR) || (state_d == S_CNT) ||
                   (state_d == S_HI)   || (state_d == S_LO);
      prog_d     = (state_d != S_IDLE);
      busy_d     = (state_d != S_IDLE);
      we_d       = (state_d == S_WRITE);
      done_d     = (state_d == S_DONE);
   end

   // State and output registers; clr wins over everything.
   always_ff @(posedge clk) begin
      if (clr) begin
         state_q    <= S_IDLE;
         addr_q     <= '0;
         data_q     <= '0;
         cnt_q      <= '0;
         err_q      <= 1'b0;
         in_ready_q <= 1'b0;
         prog_q     <= 1'b0;
         busy_q     <= 1'b0;
         we_q       <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         addr_q     <= addr_d;
         data_q     <= data_d;
         cnt_q      <= cnt_d;
         err_q      <= err_d;
         in_ready_q <= in_ready_d;
         prog_q     <= prog_d;
         busy_q     <= busy_d;
         we_q       <= we_d;
         done_q     <= done_d;
      end
   end

   assign in_ready = in_ready_q;
   assign a        = addr_q;
   assign d        = data_q;
   // A pending write is dropped if clr arrives during its WRITE cycle.
   assign we       = we_q & ~clr;
   assign prog     = prog_q;
   assign busy     = busy_q;
   assign done     = done_q;
   assign err      = err_q;

endmodule

// File: tb/tb_ram_loader.sv
module tb_ram_loader;

   logic        clk;
   logic        clr;
   logic        start;
   logic [7:0]  in_data;
   logic        in_valid;
   logic        in_ready;
   logic [7:0]  a;
   logic [11:0] d;
   logic        we;
   logic        prog;
   logic        busy;
   logic        done;
   logic        err;

   ram_loader dut (
      .clk      (clk),
      .clr      (clr),
      .start    (start),
      .in_data  (in_data),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .a        (a),
      .d        (d),
      .we       (we),
      .prog     (prog),
      .busy     (busy),
      .done     (done),
      .err      (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   // Observed RAM writes {a,d} and event counters, sampled mid-cycle.
   logic [19:0] wq[$];
   int busy_cyc = 0;
   int done_cnt = 0;
   int viol     = 0;

   always @(negedge clk) begin
      if (we) wq.push_back({a, d});
      if (busy) busy_cyc++;
      if (done) done_cnt++;
      if (we && (in_ready || !prog || !busy)) viol++;
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // Inputs change 1 time unit after the rising edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic begin_session();
      step();
      start = 1'b1;
      step();
      start = 1'b0;
   endtask

   // Offer bytes in order; a byte is consumed only when in_valid and in_ready.
   task automatic feed(input logic [7:0] bs[$], input bit throttle);
      int idx = 0;
      int g   = 0;
      while (idx < bs.size() && g < 20000) begin
         in_data  = bs[idx];
         in_valid = throttle ? 1'($urandom_range(0, 1)) : 1'b1;
         if (in_valid && in_ready) idx++;
         step();
         g++;
      end
      in_valid = 1'b0;
      if (idx < bs.size()) chk("feed_timeout", 32'(idx), 32'(bs.size()));
   endtask

   task automatic wait_idle();
      int g = 0;
      while (busy && g < 2000) begin
         step();
         g++;
      end
      if (busy) chk("idle_timeout", 32'(busy), 32'd0);
   endtask

   // Full session checked against a word-list model of the byte stream.
   task automatic run_and_check(input string nm, input logic [7:0] bs[$], input bit throttle);
      logic [7:0]  ad;
      logic [7:0]  hi;
      logic [7:0]  lo;
      logic [19:0] ew[$];
      bit          fe;
      int          n;
      int          nbad;
      int          w0;
      int          b0;
      int          d0;
      fe = 1'b0;
      ad = bs[0];
      n  = (bs[1] == 8'd0) ? 256 : int'(bs[1]);
      for (int k = 0; k < n; k++) begin
         hi = bs[2 + 2 * k];
         lo = bs[3 + 2 * k];
         ew.push_back({ad, hi[3:0], lo});
         if (hi[7:4] != 4'd0) fe = 1'b1;
         ad = ad + 8'd1;
      end
      w0 = wq.size();
      b0 = busy_cyc;
      d0 = done_cnt;
      begin_session();
      feed(bs, throttle);
      wait_idle();
      step();
      chk({nm, "_nwrites"}, 32'(wq.size() - w0), 32'(ew.size()));
      nbad = 0;
      for (int i = 0; i < ew.size(); i++) begin
         if (w0 + i >= wq.size()) nbad++;
         else if (wq[w0 + i] !== ew[i]) nbad++;
      end
      chk({nm, "_wdata_bad"}, 32'(nbad), 32'd0);
      chk({nm, "_final_a"}, 32'(a), 32'(ad));
      chk({nm, "_err"}, 32'(err), 32'(fe));
      chk({nm, "_done_pulses"}, 32'(done_cnt - d0), 32'd1);
      if (!throttle) chk({nm, "_busy_cycles"}, 32'(busy_cyc - b0), 32'(2 + 3 * n + 1));
   endtask

   typedef struct {
      logic [7:0]  addr;
      logic [7:0]  hi;
      logic [7:0]  lo;
      logic [7:0]  exp_a;
      logic [11:0] exp_d;
      logic [7:0]  exp_fa;
      logic        exp_err;
   } vec_t;

   vec_t tbl[5];

   initial begin
      logic [7:0] bs[$];
      logic [7:0] hb;
      int w0;

      tbl[0] = '{8'h10, 8'h0A, 8'hBC, 8'h10, 12'hABC, 8'h11, 1'b0};
      tbl[1] = '{8'hFF, 8'h01, 8'h23, 8'hFF, 12'h123, 8'h00, 1'b0};
      tbl[2] = '{8'h00, 8'hF7, 8'h00, 8'h00, 12'h700, 8'h01, 1'b1};
      tbl[3] = '{8'h7F, 8'h00, 8'hFF, 8'h7F, 12'h0FF, 8'h80, 1'b0};
      tbl[4] = '{8'h42, 8'h1C, 8'h5A, 8'h42, 12'hC5A, 8'h43, 1'b1};

      clr      = 1'b1;
      start    = 1'b0;
      in_data  = 8'h00;
      in_valid = 1'b0;
      repeat (3) step();
      chk("rst_a", 32'(a), 32'd0);
      chk("rst_d", 32'(d), 32'd0);
      chk("rst_ctl", {27'd0, in_ready, we, prog, busy, done}, 32'd0);
      chk("rst_err", 32'(err), 32'd0);
      clr = 1'b0;
      step();
      chk("idle_ready", 32'(in_ready), 32'd0);

      // One-word sessions with hand-computed expectations.
      for (int i = 0; i < 5; i++) begin
         w0 = wq.size();
         bs = '{tbl[i].addr, 8'h01, tbl[i].hi, tbl[i].lo};
         begin_session();
         feed(bs, 1'b0);
         wait_idle();
         step();
         chk($sformatf("tbl%0d_nwrites", i), 32'(wq.size() - w0), 32'd1);
         if (wq.size() > w0) begin
            chk($sformatf("tbl%0d_wa", i), 32'(wq[w0][19:12]), 32'(tbl[i].exp_a));
            chk($sformatf("tbl%0d_wd", i), 32'(wq[w0][11:0]), 32'(tbl[i].exp_d));
         end
         chk($sformatf("tbl%0d_final_a", i), 32'(a), 32'(tbl[i].exp_fa));
         chk($sformatf("tbl%0d_err", i), 32'(err), 32'(tbl[i].exp_err));
      end

      // Basic two-word load, with literal expectations as well as the model.
      bs = '{8'h10, 8'h02, 8'h0A, 8'hBC, 8'h03, 8'h45};
      run_and_check("basic", bs, 1'b0);
      chk("basic_w0", 32'(wq[wq.size() - 2]), 32'h10ABC);
      chk("basic_w1", 32'(wq[wq.size() - 1]), 32'h11345);
      chk("basic_a", 32'(a), 32'h12);

      // Count byte zero: 256 words, address wraps back to the start.
      bs = '{8'hC0, 8'h00};
      for (int k = 0; k < 512; k++) bs.push_back(8'($urandom_range(0, 15)));
      run_and_check("n256", bs, 1'b0);
      chk("n256_a", 32'(a), 32'hC0);

      // Random sessions, each run unthrottled and then with random in_valid.
      for (int r = 0; r < 6; r++) begin
         int n;
         n  = $urandom_range(1, 6);
         bs = {};
         bs.push_back((r == 0) ? 8'hFD : 8'($urandom));
         bs.push_back(8'(n));
         for (int k = 0; k < n; k++) begin
            hb = ($urandom_range(0, 3) == 0) ? 8'($urandom) : {4'h0, 4'($urandom)};
            bs.push_back(hb);
            bs.push_back(8'($urandom));
         end
         run_and_check($sformatf("rnd%0d", r), bs, 1'b0);
         run_and_check($sformatf("thr%0d", r), bs, 1'b1);
      end

      // err stays set while idle and clears on the next accepted start.
      bs = '{8'h50, 8'h01, 8'hF7, 8'h11};
      run_and_check("errset", bs, 1'b0);
      repeat (3) step();
      chk("err_sticky", 32'(err), 32'd1);
      begin_session();
      chk("err_cleared", 32'(err), 32'd0);
      bs = '{8'h60, 8'h01, 8'h01, 8'h22};
      feed(bs, 1'b0);
      wait_idle();
      chk("err_after_clean", 32'(err), 32'd0);

      // clr during the WRITE cycle drops the pending word.
      w0 = wq.size();
      begin_session();
      bs = '{8'h20, 8'h01, 8'h05, 8'h67};
      feed(bs, 1'b0);
      chk("write_cycle_we", 32'(we), 32'd1);
      clr = 1'b1;
      #1;
      chk("clr_masks_we", 32'(we), 32'd0);
      step();
      clr = 1'b0;
      chk("clr_a", 32'(a), 32'd0);
      chk("clr_d", 32'(d), 32'd0);
      chk("clr_ctl", {27'd0, in_ready, we, prog, busy, done}, 32'd0);
      step();
      step();
      chk("clr_no_write", 32'(wq.size() - w0), 32'd0);
      bs = '{8'h21, 8'h01, 8'h08, 8'h9A};
      run_and_check("after_clr", bs, 1'b0);

      // start during HI is ignored.
      w0 = wq.size();
      begin_session();
      bs = '{8'h30, 8'h02};
      feed(bs, 1'b0);
      start = 1'b1;
      step();
      step();
      start = 1'b0;
      chk("ign_start_a", 32'(a), 32'h30);
      chk("ign_start_ready", 32'(in_ready), 32'd1);
      bs = '{8'h01, 8'h23, 8'h04, 8'h56};
      feed(bs, 1'b0);
      wait_idle();
      step();
      chk("ign_start_n", 32'(wq.size() - w0), 32'd2);
      if (wq.size() >= w0 + 2) begin
         chk("ign_start_w0", 32'(wq[w0]), 32'h30123);
         chk("ign_start_w1", 32'(wq[w0 + 1]), 32'h31456);
      end

      // A byte offered together with start in IDLE is not consumed.
      w0 = wq.size();
      step();
      start    = 1'b1;
      in_valid = 1'b1;
      in_data  = 8'h55;
      step();
      start = 1'b0;
      bs = '{8'h40, 8'h01, 8'h0F, 8'hEE};
      feed(bs, 1'b0);
      wait_idle();
      step();
      chk("idle_byte_n", 32'(wq.size() - w0), 32'd1);
      if (wq.size() > w0) chk("idle_byte_w", 32'(wq[w0]), 32'h40FEE);

      chk("we_protocol_viol", 32'(viol), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/ram_loader.md
RAM_LOADER -- requirements
Module: ram_loader

Interface
REQ-001 Parameters: none; address width is fixed at 8 and data width is fixed at 12.
REQ-002 clk  input  1  system clock; all state changes on posedge clk.
REQ-003 clr  input  1  synchronous, active-high reset; sampled on posedge clk.
REQ-004 start  input  1  begins a load session; sampled only in IDLE.
REQ-005 in_data  input  8  byte stream from the programming source.
REQ-006 in_valid  input  1  in_data is valid this cycle.
REQ-007 in_ready  output  1  loader accepts a byte this cycle; a transfer occurs when in_valid and in_ready are both high.
REQ-008 a  output  8  RAM address, connected to ram256x12 a.
REQ-009 d  output  12  RAM write data, connected to ram256x12 d.
REQ-010 we  output  1  RAM write enable, one cycle per word.
REQ-011 prog  output  1  programming mode; forces the RAM output to high-Z.
REQ-012 busy  output  1  high in every state except IDLE.
REQ-013 done  output  1  one-cycle pulse at session end.
REQ-014 err  output  1  sticky format-error flag.

Function
REQ-015 The loader SHALL implement the states IDLE, ADDR, CNT, HI, LO, WRITE and DONE.
REQ-016 IDLE: in_ready=0 and prog=0; start=1 moves to ADDR next cycle and clears err.
REQ-017 ADDR: in_ready=1; an accepted byte loads the address register and the state moves to CNT.
REQ-018 CNT: in_ready=1; an accepted byte N loads the 9-bit word count (N=0 loads 256) and the state moves to HI.
REQ-019 HI: in_ready=1; an accepted byte sets d[11:8]=in_data[3:0]; if in_data[7:4]!=0, err is set and those bits are discarded; the state moves to LO.
REQ-020 LO: in_ready=1; an accepted byte sets d[7:0]=in_data and the state moves to WRITE.
REQ-021 WRITE: in_ready=0, we=1 for exactly one cycle, with a and d holding the current address and word.
REQ-022 WRITE exit: the address increments by 1, wrapping 8'hFF to 8'h00, and the count decrements by 1; the next state is DONE if the count reaches 0, otherwise HI.
REQ-023 DONE: done=1 for one cycle, in_ready=0, then IDLE.
REQ-024 prog SHALL be high in ADDR, CNT, HI, LO, WRITE and DONE.
REQ-025 When in_valid=0 in a byte state, the loader SHALL hold its state with no side effects; no timeout is applied.
REQ-026 start SHALL be ignored outside IDLE; a simultaneous start and byte in IDLE SHALL NOT consume the byte.
REQ-027 we SHALL never be asserted outside WRITE.
REQ-028 After DONE, a holds the last written address plus 1, modulo 256.
REQ-029 Latency: the WRITE cycle is the first cycle after the LO byte is accepted; the minimum session time is 2+3N+1 cycles after leaving IDLE.
REQ-030 err SHALL stay set until the next accepted start or clr.

Reset
REQ-031 With clr=1 at posedge clk, the loader SHALL enter IDLE with a=0, d=0, count=0, we=0, prog=0, busy=0, done=0, err=0 and in_ready=0.
REQ-032 clr SHALL have priority over start and byte transfers.
REQ-033 clr mid-session SHALL abort without any further write; a word whose LO byte was accepted but not yet written SHALL be dropped.

Verification
REQ-034 Basic load: start, then bytes 10,02,0A,BC,03,45 with in_valid held high -> we pulses at a=10 with d=ABC and at a=11 with d=345; done pulses; the final a=12; err=0.
REQ-035 Wrap and N=0: start, then bytes FF,01,01,23 -> one write at a=FF with d=123; the final a=00. Separately, start with N=00 and 512 data bytes -> 256 writes.
REQ-036 Throttling: in_valid toggled randomly -> identical writes to the unthrottled run; no transfer occurs while in_ready=0.
REQ-037 Format error: a HI byte of F7 -> d[11:8]=7, err=1 until the next start, and the write still occurs.
REQ-038 Reset mid-session: clr asserted in the cycle after the LO byte is accepted -> no we pulse follows; all outputs take their reset values; the next session loads normally.
REQ-039 Ignored start: start pulsed during HI -> no change of state or address.
